// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle for alu_pipe.
// The source/consumer side uses master; the ALU uses slave.
interface alu_pipe_if #(
  parameter int unsigned N_BITS   = 8,
  parameter int unsigned N_OP     = 6,
  parameter int unsigned TAG_BITS = 4
);
  logic                i_valid;
  logic                o_ready;
  logic [N_BITS-1:0]   i_A;
  logic [N_BITS-1:0]   i_B;
  logic [N_OP-1:0]     i_OP;
  logic [TAG_BITS-1:0] i_tag;
  logic                o_valid;
  logic                i_ready;
  logic [N_BITS-1:0]   o_res;
  logic [TAG_BITS-1:0] o_tag;
  logic [3:0]          o_flags;
  logic                o_err;

  modport master (
    output i_valid, i_A, i_B, i_OP, i_tag, i_ready,
    input  o_ready, o_valid, o_res, o_tag, o_flags, o_err
  );

  modport slave (
    input  i_valid, i_A, i_B, i_OP, i_tag, i_ready,
    output o_ready, o_valid, o_res, o_tag, o_flags, o_err
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 captures operands, S2 holds result/flags/err/tag.
// Valid/ready on both sides; each stage advances when the stage ahead can take its contents.
module alu_pipe #(
  parameter int unsigned N_BITS   = 8,
  parameter int unsigned N_OP     = 6,
  parameter int unsigned TAG_BITS = 4
) (
  input logic        clock,
  input logic        reset,
  alu_pipe_if.slave  bus
);
  localparam int unsigned MSB = N_BITS - 1;

  localparam logic [N_OP-1:0] OP_ADD = N_OP'(6'b100000);
  localparam logic [N_OP-1:0] OP_SUB = N_OP'(6'b100010);
  localparam logic [N_OP-1:0] OP_AND = N_OP'(6'b100100);
  localparam logic [N_OP-1:0] OP_OR  = N_OP'(6'b100101);
  localparam logic [N_OP-1:0] OP_XOR = N_OP'(6'b100110);
  localparam logic [N_OP-1:0] OP_NOR = N_OP'(6'b100111);
  localparam logic [N_OP-1:0] OP_SLL = N_OP'(6'b000000);
  localparam logic [N_OP-1:0] OP_SRL = N_OP'(6'b000010);
  localparam logic [N_OP-1:0] OP_SRA = N_OP'(6'b000011);

  logic                s1_valid;
  logic                s2_valid;
  logic                s1_adv;
  logic                s2_adv;
  logic [N_BITS-1:0]   s1_a;
  logic [N_BITS-1:0]   s1_b;
  logic [N_OP-1:0]     s1_op;
  logic [TAG_BITS-1:0] s1_tag;
  logic [N_BITS-1:0]   s2_res;
  logic [3:0]          s2_flags;
  logic                s2_err;
  logic [TAG_BITS-1:0] s2_tag;

  logic [N_BITS:0]     sum_ext;
  logic [N_BITS:0]     diff_ext;
  logic                shift_big;
  logic [N_BITS-1:0]   alu_res;
  logic                alu_c;
  logic                alu_v;
  logic                alu_err;
  logic [3:0]          alu_flags;

  // S1 may refill in the same cycle S2 drains, so readiness chains back from the consumer.
  always_comb begin
    s2_adv = !s2_valid || bus.i_ready;
    s1_adv = !s1_valid || s2_adv;
  end

  assign bus.o_ready = s1_adv;

  always_comb begin
    sum_ext   = {1'b0, s1_a} + {1'b0, s1_b};
    diff_ext  = {1'b0, s1_a} - {1'b0, s1_b};
    shift_big = (s1_b >= N_BITS'(N_BITS));
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_err   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        alu_res = sum_ext[MSB:0];
        alu_c   = sum_ext[N_BITS];
        alu_v   = (s1_a[MSB] == s1_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        alu_res = diff_ext[MSB:0];
        alu_c   = diff_ext[N_BITS];
        alu_v   = (s1_a[MSB] != s1_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
      end
      OP_AND:  alu_res = s1_a & s1_b;
      OP_OR:   alu_res = s1_a | s1_b;
      OP_XOR:  alu_res = s1_a ^ s1_b;
      OP_NOR:  alu_res = ~(s1_a | s1_b);
      OP_SLL:  alu_res = shift_big ? '0 : (s1_a << s1_b);
      OP_SRL:  alu_res = shift_big ? '0 : (s1_a >> s1_b);
      OP_SRA:  alu_res = shift_big ? {N_BITS{s1_a[MSB]}} : N_BITS'($signed(s1_a) >>> s1_b);
      default: alu_err = 1'b1;
    endcase
    alu_flags = alu_err ? 4'b0000 : {(alu_res == '0), alu_res[MSB], alu_c, alu_v};
    if (alu_err) alu_res = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_a   <= bus.i_A;
        s1_b   <= bus.i_B;
        s1_op  <= bus.i_OP;
        s1_tag <= bus.i_tag;
      end
    end
  end

  // S2 contents only change on advance, which keeps outputs stable under backpressure.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_flags <= '0;
      s2_err   <= 1'b0;
      s2_tag   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res   <= alu_res;
        s2_flags <= alu_flags;
        s2_err   <= alu_err;
        s2_tag   <= s1_tag;
      end
    end
  end

  assign bus.o_valid = s2_valid;
  assign bus.o_res   = s2_res;
  assign bus.o_flags = s2_flags;
  assign bus.o_err   = s2_err;
  assign bus.o_tag   = s2_tag;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, backpressure, streaming,
// randomized traffic against an arithmetic reference model, and mid-flight reset.
module tb_alu_pipe;
  localparam int unsigned NB = 8;
  localparam int unsigned NO = 6;
  localparam int unsigned TW = 4;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] tag;
    logic [3:0] flags;
    logic       err;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alu_pipe_if #(.N_BITS(NB), .N_OP(NO), .TAG_BITS(TW)) bus ();
  alu_pipe #(.N_BITS(NB), .N_OP(NO), .TAG_BITS(TW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t obs;
  logic acc, outx;

  logic [5:0] legal_ops [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                6'b100111, 6'b000000, 6'b000010, 6'b000011};

  // Directed vectors: op, A, B, expected result, {Z,N,C,V}, err
  logic [5:0] d_op  [12] = '{6'b100000, 6'b100010, 6'b100010, 6'b100100, 6'b000011, 6'b000010,
                             6'b000000, 6'b000011, 6'b111111, 6'b100110, 6'b100111, 6'b100101};
  logic [7:0] d_a   [12] = '{8'h7F, 8'h00, 8'h80, 8'h0F, 8'h80, 8'h80, 8'h01, 8'h80, 8'h05, 8'h05, 8'h00, 8'h0A};
  logic [7:0] d_b   [12] = '{8'h01, 8'h01, 8'h01, 8'hF0, 8'd3,  8'd9,  8'd7,  8'd200, 8'h03, 8'h03, 8'h00, 8'h50};
  logic [7:0] d_res [12] = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'hF0, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h06, 8'hFF, 8'h5A};
  logic [3:0] d_fl  [12] = '{4'b0101, 4'b0110, 4'b0001, 4'b1000, 4'b0100, 4'b1000,
                             4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
  logic       d_err [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  // Reference model: plain integer arithmetic on the opcode's meaning
  function automatic exp_t ref_op(logic [7:0] a, logic [7:0] b, logic [5:0] op, logic [3:0] tag);
    exp_t e;
    int ua, ub, sa, sb, r, sr;
    logic c, v, legal;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 0; c = 1'b0; v = 1'b0; legal = 1'b1;
    case (op)
      6'b100000: begin r = ua + ub; sr = sa + sb; c = (r > 255); v = (sr > 127) || (sr < -128); end
      6'b100010: begin r = ua - ub; sr = sa - sb; c = (ua < ub); v = (sr > 127) || (sr < -128); end
      6'b100100: r = ua & ub;
      6'b100101: r = ua | ub;
      6'b100110: r = ua ^ ub;
      6'b100111: r = ~(ua | ub);
      6'b000000: r = (ub >= 8) ? 0 : (ua << ub);
      6'b000010: r = (ub >= 8) ? 0 : (ua >> ub);
      6'b000011: r = sa >>> ((ub > 7) ? 7 : ub);
      default:   legal = 1'b0;
    endcase
    e.res   = legal ? r[7:0] : 8'h00;
    e.tag   = tag;
    e.err   = !legal;
    e.flags = legal ? {(e.res == 8'h00), e.res[7], c, v} : 4'b0000;
    return e;
  endfunction

  function automatic logic [5:0] rand_op();
    int k;
    k = $urandom_range(0, 9);
    if (k == 9) return 6'($urandom);
    return legal_ops[k];
  endfunction

  function automatic logic [7:0] rand_b();
    if ($urandom_range(0, 1) == 1) return 8'($urandom_range(0, 11));
    return 8'($urandom);
  endfunction

  // Drive one cycle's inputs at the falling edge and report what the next rising edge transfers
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                      input logic [3:0] tag, input logic rdy, output logic took_in, output logic took_out);
    @(negedge clock);
    bus.i_valid = v; bus.i_A = a; bus.i_B = b; bus.i_OP = op; bus.i_tag = tag; bus.i_ready = rdy;
    #1;
    took_in  = v && bus.o_ready;
    took_out = bus.o_valid && rdy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_valid = 1'b0; bus.i_A = '0; bus.i_B = '0; bus.i_OP = '0; bus.i_tag = '0; bus.i_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock); #1;
    obs = {bus.o_res, bus.o_tag, bus.o_flags, bus.o_err};
    checks++;
    if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    checks++;
    if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
  endtask

  task automatic test_directed();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      e = '{res: d_res[i], tag: 4'(i), flags: d_fl[i], err: d_err[i]};
      step(1'b1, d_a[i], d_b[i], d_op[i], 4'(i), 1'b1, acc, outx);
      checks++;
      if (acc !== 1'b1) begin failures++; $display("FAIL dir%0d_accept got=%b exp=1", i, acc); end
      step(1'b0, 8'h00, 8'h00, 6'h00, 4'h0, 1'b1, acc, outx);
      checks++;
      if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_early_valid got=%b exp=0", i, bus.o_valid); end
      step(1'b0, 8'h00, 8'h00, 6'h00, 4'h0, 1'b1, acc, outx);
      obs = {bus.o_res, bus.o_tag, bus.o_flags, bus.o_err};
      checks++;
      if (bus.o_valid !== 1'b1 || obs !== e) begin
        failures++;
        $display("FAIL dir%0d_result got valid=%b res=%h tag=%h fl=%b err=%b exp res=%h tag=%h fl=%b err=%b",
                 i, bus.o_valid, obs.res, obs.tag, obs.flags, obs.err, e.res, e.tag, e.flags, e.err);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ra [4];
    logic [7:0] rb [4];
    logic [5:0] ro [4];
    int idx, nout, first_c, last_c;
    for (int i = 0; i < 4; i++) begin ra[i] = 8'($urandom); rb[i] = rand_b(); ro[i] = legal_ops[$urandom_range(0, 8)]; end
    exp_q.delete();
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, ra[idx], rb[idx], ro[idx], 4'(idx), 1'b0, acc, outx);
      if (c >= 2) begin
        obs = {bus.o_res, bus.o_tag, bus.o_flags, bus.o_err};
        checks++;
        if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_c%0d got=%b exp=0", c, bus.o_ready); end
        checks++;
        if (bus.o_valid !== 1'b1 || obs !== exp_q[0]) begin
          failures++; $display("FAIL bp_hold_c%0d got valid=%b out=%h exp out=%h", c, bus.o_valid, obs, exp_q[0]);
        end
      end
      if (acc) begin exp_q.push_back(ref_op(ra[idx], rb[idx], ro[idx], 4'(idx))); idx++; end
    end
    checks++;
    if (idx !== 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", idx); end
    nout = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12 && (idx < 4 || exp_q.size() > 0); c++) begin
      step(idx < 4, ra[idx % 4], rb[idx % 4], ro[idx % 4], 4'(idx), 1'b1, acc, outx);
      if (outx) begin
        obs = {bus.o_res, bus.o_tag, bus.o_flags, bus.o_err};
        checks++;
        if (exp_q.size() == 0 || obs !== exp_q[0]) begin
          failures++; $display("FAIL bp_drain_out%0d got=%h exp=%h", nout, obs, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (first_c < 0) first_c = c;
        last_c = c;
        nout++;
      end
      if (acc) begin exp_q.push_back(ref_op(ra[idx], rb[idx], ro[idx], 4'(idx))); idx++; end
    end
    checks++;
    if (nout !== 4 || (last_c - first_c) !== 3) begin
      failures++; $display("FAIL bp_no_gaps got outs=%0d span=%0d exp outs=4 span=3", nout, last_c - first_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic [5:0] op;
    int sent;
    exp_q.delete();
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      a = 8'($urandom); b = rand_b(); op = rand_op();
      step(sent < 24, a, b, op, 4'(sent), 1'b1, acc, outx);
      checks++;
      if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_c%0d got=%b exp=1", c, bus.o_ready); end
      if (c >= 2 && c < 26) begin
        checks++;
        if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL b2b_bubble_c%0d got=%b exp=1", c, bus.o_valid); end
      end
      if (outx) begin
        obs = {bus.o_res, bus.o_tag, bus.o_flags, bus.o_err};
        checks++;
        if (exp_q.size() == 0 || obs !== exp_q[0]) begin
          failures++; $display("FAIL b2b_out_c%0d got=%h exp=%h", c, obs, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (acc) begin exp_q.push_back(ref_op(a, b, op, 4'(sent))); sent++; end
    end
    checks++;
    if (exp_q.size() !== 0 || sent !== 24) begin
      failures++; $display("FAIL b2b_complete got left=%0d sent=%0d exp left=0 sent=24", exp_q.size(), sent);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic [5:0] op;
    logic [3:0] tag;
    logic v, rdy, exp_rdy;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      a = 8'($urandom); b = rand_b(); op = rand_op(); tag = 4'($urandom);
      v = ($urandom_range(0, 3) != 0); rdy = ($urandom_range(0, 3) != 0);
      step(v, a, b, op, tag, rdy, acc, outx);
      exp_rdy = !(exp_q.size() >= 2 && !rdy);
      checks++;
      if (bus.o_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready_c%0d got=%b exp=%b", c, bus.o_ready, exp_rdy); end
      if (exp_q.size() == 0) begin
        checks++;
        if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL rnd_spurious_c%0d got=%b exp=0", c, bus.o_valid); end
      end else if (bus.o_valid) begin
        obs = {bus.o_res, bus.o_tag, bus.o_flags, bus.o_err};
        checks++;
        if (obs !== exp_q[0]) begin failures++; $display("FAIL rnd_out_c%0d got=%h exp=%h", c, obs, exp_q[0]); end
      end
      if (outx && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_op(a, b, op, tag));
    end
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      step(1'b0, 8'h00, 8'h00, 6'h00, 4'h0, 1'b1, acc, outx);
      if (outx) begin
        obs = {bus.o_res, bus.o_tag, bus.o_flags, bus.o_err};
        checks++;
        if (obs !== exp_q[0]) begin failures++; $display("FAIL rnd_drain got=%h exp=%h", obs, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL rnd_drain_timeout got left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    exp_q.delete();
    step(1'b1, 8'h12, 8'h34, 6'b100000, 4'hA, 1'b0, acc, outx);
    step(1'b1, 8'h56, 8'h78, 6'b100110, 4'hB, 1'b0, acc, outx);
    @(posedge clock); #1;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) begin
      failures++; $display("FAIL rst_prefill got valid=%b ready=%b exp valid=1 ready=0", bus.o_valid, bus.o_ready);
    end
    #1 reset = 1'b1;
    #1;
    obs = {bus.o_res, bus.o_tag, bus.o_flags, bus.o_err};
    checks++;
    if (bus.o_valid !== 1'b0 || obs !== '0) begin
      failures++; $display("FAIL rst_async got valid=%b out=%h exp valid=0 out=0", bus.o_valid, obs);
    end
    bus.i_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", bus.o_ready); end
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 8'h00, 8'h00, 6'h00, 4'h0, 1'b1, acc, outx);
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_tag !== 4'h0) begin
        failures++; $display("FAIL rst_stale_c%0d got valid=%b tag=%h exp valid=0 tag=0", c, bus.o_valid, bus.o_tag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
